out_uart_tx: RTL



---
 rtl/out_uart_tx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/out_uart_tx.sv
// out_uart_tx: captures each new value on the core's output bus, queues it in
// a small circular FIFO and serialises the queue as UART frames on one pin.
// Default build sends 8N1 frames (10*CLKS_PER_BIT cycles). Defining
// OUT_UART_TX_PARITY_EN inserts an even-parity bit (11*CLKS_PER_BIT cycles).
// tx is a registered copy of the level the FSM state calls for, so it lags
// the state register by one cycle.
module out_uart_tx #(
    parameter int CLKS_PER_BIT = 4,   // 2..255
    parameter int DEPTH        = 4    // power of two, 2..16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [7:0] BAUD_LAST  = 8'(CLKS_PER_BIT - 1);

`ifdef OUT_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // change detector and sticky drop flag
    logic [7:0] r_last;
    logic       r_primed;
    logic       r_overflow;

    // transmitter
    state_t     r_state, w_state_next;
    logic [7:0] r_baud, w_baud_next;
    logic [2:0] r_bit_idx, w_bit_idx_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_tx, w_tx_next;

    logic w_pop;
    logic w_push_req;
    logic w_push_ok;
    logic w_full;
    logic w_empty;
    logic w_baud_done;

    assign w_full      = (r_count == FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_baud_done = (r_baud == BAUD_LAST);

    // A capture is requested for the first value after reset and then only on change.
    assign w_push_req = en && (!r_primed || (data_in != r_last));
    // A full FIFO still accepts a push when the transmitter pops on the same edge.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    // FIFO storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Capture tracking, FIFO pointers/count and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last     <= 8'h00;
            r_primed   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_req) begin
                r_last   <= data_in;
                r_primed <= 1'b1;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Transmitter state register and the registered tx level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= 8'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    // Next-state, baud/bit counting and the line level for the current state.
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_tx_next      = 1'b1;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_baud_next  = 8'd0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_baud_next    = 8'd0;
                    w_bit_idx_next = 3'd0;
                    w_state_next   = S_DATA;
                end else begin
                    w_baud_next = r_baud + 8'd1;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[r_bit_idx];
                if (w_baud_done) begin
                    w_baud_next = 8'd0;
                    if (r_bit_idx == 3'd7) begin
`ifdef OUT_UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + 8'd1;
                end
            end
`ifdef OUT_UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx_next = ^r_shift;
                if (w_baud_done) begin
                    w_baud_next  = 8'd0;
                    w_state_next = S_STOP;
                end else begin
                    w_baud_next = r_baud + 8'd1;
                end
            end
`endif
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_baud_done) begin
                    w_baud_next  = 8'd0;
                    w_state_next = S_IDLE;
                end else begin
                    w_baud_next = r_baud + 8'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign tx        = r_tx;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign fifo_full = w_full;
    assign overflow  = r_overflow;

endmodule
